// File: rtl/lfu_age_sched.sv
// LFU usage counters with periodic aging sweep and registered victim select.
// Every AGE_PERIOD timer ticks, each counter is halved, one entry per cycle.
// Optional statistics outputs are enabled by defining LFU_AGE_STATS_EN.
module lfu_age_sched #(
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_W       = 8,
  parameter int AGE_PERIOD  = 4
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           hit_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] hit_idx,
  input  logic                           fill_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] fill_idx,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_idx,
  output logic [CNT_W-1:0]               rd_cnt,
  output logic [$clog2(NUM_ENTRIES)-1:0] victim_idx,
  output logic [CNT_W-1:0]               victim_cnt,
  output logic                           sweep_busy,
  output logic                           sweep_done
`ifdef LFU_AGE_STATS_EN
  ,
  output logic [15:0]                    sweep_count,
  output logic [15:0]                    merged_req
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TCK_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(AGE_PERIOD - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_pending, w_pending_nxt;
  logic [TCK_W-1:0] r_tick_cnt;
  logic [CNT_W-1:0] r_cnt [NUM_ENTRIES];
  logic [CNT_W-1:0] w_cnt_nxt [NUM_ENTRIES];
  logic [IDX_W-1:0] r_vic_idx, w_min_idx;
  logic [CNT_W-1:0] r_vic_cnt, w_min_cnt;
  logic             w_age_req;
  logic             w_last;

  assign w_age_req = tick && (r_tick_cnt == TCK_LAST);
  assign w_last    = (r_state == SWEEP) && (r_ptr == PTR_LAST);

  // Tick counter: counts in every state, wraps at the aging period.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (tick) begin
      r_tick_cnt <= (r_tick_cnt == TCK_LAST) ? '0 : r_tick_cnt + TCK_W'(1);
    end
  end

  // Sweep FSM state, pointer and one-deep pending request.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Next-state logic. A request arriving on the final sweep cycle restarts
  // the sweep directly; if one was already pending it takes the pending slot.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_pending_nxt = r_pending;
    case (r_state)
      IDLE: begin
        w_pending_nxt = 1'b0;
        if (w_age_req) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        if (r_ptr == PTR_LAST) begin
          w_ptr_nxt = '0;
          if (r_pending || w_age_req) begin
            w_pending_nxt = r_pending && w_age_req;
          end else begin
            w_state_nxt   = IDLE;
            w_pending_nxt = 1'b0;
          end
        end else begin
          w_ptr_nxt = r_ptr + IDX_W'(1);
          if (w_age_req) w_pending_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_ptr_nxt     = '0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Per-entry counter update: fill > hit-while-aged > hit > aging.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (fill_valid && (fill_idx == IDX_W'(i))) begin
        w_cnt_nxt[i] = CNT_W'(1);
      end else if (hit_valid && (hit_idx == IDX_W'(i)) &&
                   (r_state == SWEEP) && (r_ptr == IDX_W'(i))) begin
        w_cnt_nxt[i] = (r_cnt[i] >> 1) + CNT_W'(1);
      end else if (hit_valid && (hit_idx == IDX_W'(i))) begin
        w_cnt_nxt[i] = (r_cnt[i] == CNT_MAX) ? r_cnt[i] : r_cnt[i] + CNT_W'(1);
      end else if ((r_state == SWEEP) && (r_ptr == IDX_W'(i))) begin
        w_cnt_nxt[i] = r_cnt[i] >> 1;
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Minimum search; strict less-than keeps the lowest index on ties.
  always_comb begin
    w_min_idx = '0;
    w_min_cnt = r_cnt[0];
    for (int unsigned i = 1; i < NUM_ENTRIES; i++) begin
      if (r_cnt[i] < w_min_cnt) begin
        w_min_idx = IDX_W'(i);
        w_min_cnt = r_cnt[i];
      end
    end
  end

  // Registered victim outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_vic_idx <= '0;
      r_vic_cnt <= '0;
    end else begin
      r_vic_idx <= w_min_idx;
      r_vic_cnt <= w_min_cnt;
    end
  end

`ifdef LFU_AGE_STATS_EN
  logic [15:0] r_sweep_count;
  logic [15:0] r_merged_req;

  // Completed sweeps (wrapping) and merged age requests (saturating).
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sweep_count <= '0;
      r_merged_req  <= '0;
    end else begin
      if (w_last) r_sweep_count <= r_sweep_count + 16'd1;
      if ((r_state == SWEEP) && !w_last && w_age_req && r_pending &&
          (r_merged_req != '1))
        r_merged_req <= r_merged_req + 16'd1;
    end
  end

  assign sweep_count = r_sweep_count;
  assign merged_req  = r_merged_req;
`endif

  assign rd_cnt     = r_cnt[rd_idx];
  assign victim_idx = r_vic_idx;
  assign victim_cnt = r_vic_cnt;
  assign sweep_busy = (r_state == SWEEP);
  assign sweep_done = w_last;

endmodule

// File: tb/tb_lfu_age_sched.sv
// Self-checking bench for lfu_age_sched: constant vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_lfu_age_sched;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int P  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_idx = '0;
  logic        fill_valid = 1'b0;
  logic [1:0]  fill_idx = '0;
  logic [1:0]  rd_idx = '0;
  logic [7:0]  rd_cnt;
  logic [1:0]  victim_idx;
  logic [7:0]  victim_cnt;
  logic        sweep_busy;
  logic        sweep_done;
`ifdef LFU_AGE_STATS_EN
  logic [15:0] sweep_count;
  logic [15:0] merged_req;
`endif

  lfu_age_sched #(
    .NUM_ENTRIES (N),
    .CNT_W       (CW),
    .AGE_PERIOD  (P)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .tick       (tick),
    .hit_valid  (hit_valid),
    .hit_idx    (hit_idx),
    .fill_valid (fill_valid),
    .fill_idx   (fill_idx),
    .rd_idx     (rd_idx),
    .rd_cnt     (rd_cnt),
    .victim_idx (victim_idx),
    .victim_cnt (victim_cnt),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done)
`ifdef LFU_AGE_STATS_EN
    ,
    .sweep_count(sweep_count),
    .merged_req (merged_req)
`endif
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: usage counts, tick phase, sweep position and the
  // number of sweeps still owed (at most one queued behind the active one).
  int m_cnt [N];
  int m_tick;
  bit m_active;
  int m_pos;
  bit m_owed;
  int m_vidx, m_vcnt;
  int m_sweeps, m_merged;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_tick = 0; m_active = 0; m_pos = 0; m_owed = 0;
    m_vidx = 0; m_vcnt = 0; m_sweeps = 0; m_merged = 0;
  endtask

  task automatic model_step(input bit tk, input bit hv, input int hi,
                            input bit fv, input int fi);
    int best;
    int aged;
    bit req;
    best = 0;
    for (int i = 1; i < N; i++) if (m_cnt[i] < m_cnt[best]) best = i;
    aged = m_active ? m_pos : -1;
    for (int i = 0; i < N; i++) begin
      if (fv && fi == i)                  m_cnt[i] = 1;
      else if (hv && hi == i && aged == i) m_cnt[i] = m_cnt[i] / 2 + 1;
      else if (hv && hi == i)             m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
      else if (aged == i)                 m_cnt[i] = m_cnt[i] / 2;
    end
    m_vidx = best;
    m_vcnt = m_cnt[best];
    // victim reflects counters before this edge's update
    m_vcnt = 0;
    req = tk && (m_tick == P - 1);
    if (tk) m_tick = (m_tick + 1) % P;
    if (!m_active) begin
      if (req) begin m_active = 1; m_pos = 0; end
    end else if (m_pos == N - 1) begin
      m_sweeps = (m_sweeps + 1) % 65536;
      if (m_owed || req) begin
        m_pos  = 0;
        m_owed = m_owed && req;
      end else begin
        m_active = 0;
      end
    end else begin
      m_pos++;
      if (req) begin
        if (m_owed) m_merged = (m_merged < 65535) ? m_merged + 1 : 65535;
        else        m_owed = 1;
      end
    end
  endtask

  // Pre-edge copy of the counters used for the registered victim value.
  int m_prev [N];

  task automatic check_model(input string tag);
    check({tag, ":busy"},   int'(sweep_busy), int'(m_active));
    check({tag, ":done"},   int'(sweep_done), int'(m_active && m_pos == N - 1));
    check({tag, ":vidx"},   int'(victim_idx), m_vidx);
    check({tag, ":vcnt"},   int'(victim_cnt), m_vcnt);
    check({tag, ":rd_cnt"}, int'(rd_cnt),     m_cnt[int'(rd_idx)]);
`ifdef LFU_AGE_STATS_EN
    check({tag, ":sweep_count"}, int'(sweep_count), m_sweeps);
    check({tag, ":merged_req"},  int'(merged_req),  m_merged);
`endif
  endtask

  // One clock cycle: drive, let the edge pass, advance the model, compare.
  task automatic cyc(input string tag, input bit tk, input bit hv, input int hi,
                     input bit fv, input int fi, input int rd);
    tick = tk; hit_valid = hv; hit_idx = 2'(hi);
    fill_valid = fv; fill_idx = 2'(fi); rd_idx = 2'(rd);
    for (int i = 0; i < N; i++) m_prev[i] = m_cnt[i];
    @(posedge clock);
    #1;
    model_step(tk, hv, hi, fv, fi);
    begin
      int b;
      b = 0;
      for (int i = 1; i < N; i++) if (m_prev[i] < m_prev[b]) b = i;
      m_vidx = b;
      m_vcnt = m_prev[b];
    end
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int rd);
    cyc(tag, 0, 0, 0, 0, 0, rd);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic do_reset(input int rd);
    tick = 0; hit_valid = 0; fill_valid = 0; rd_idx = 2'(rd);
    #2;
    rst = 1'b1;
    #1;
    check("rst:busy",   int'(sweep_busy), 0);
    check("rst:done",   int'(sweep_done), 0);
    check("rst:vidx",   int'(victim_idx), 0);
    check("rst:vcnt",   int'(victim_cnt), 0);
    check("rst:rd_cnt", int'(rd_cnt),     0);
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  task automatic build_8642();
    int tgt [N];
    tgt[0] = 8; tgt[1] = 6; tgt[2] = 4; tgt[3] = 2;
    do_reset(0);
    for (int e = 0; e < N; e++)
      for (int k = 0; k < tgt[e]; k++) cyc("build", 0, 1, e, 0, 0, e);
  endtask

  typedef struct {
    bit tk; bit hv; int hi; bit fv; int fi; int rd;
    int e_rd; int e_vidx; int e_vcnt;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
    vt[1] = '{0, 1, 1, 0, 0, 1, 2, 0, 0};
    vt[2] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
    vt[3] = '{0, 1, 3, 0, 0, 3, 1, 0, 0};
    vt[4] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[5] = '{0, 1, 0, 1, 2, 2, 1, 2, 0};
    vt[6] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    vt[7] = '{0, 1, 1, 0, 0, 1, 2, 1, 1};
    vt[8] = '{0, 0, 0, 0, 0, 3, 1, 2, 1};

    // Reset and idle: nothing moves without ticks or traffic.
    do_reset(0);
    for (int k = 0; k < 6; k++) idle("idle", k % N);
    check("idle:vidx", int'(victim_idx), 0);

    // Vector table: hits, fills, fill-over-hit, tie-break.
    do_reset(0);
    for (int v = 0; v < 9; v++) begin
      cyc("vec", vt[v].tk, vt[v].hv, vt[v].hi, vt[v].fv, vt[v].fi, vt[v].rd);
      check($sformatf("vec%0d:rd_cnt", v), int'(rd_cnt),     vt[v].e_rd);
      check($sformatf("vec%0d:vidx", v),   int'(victim_idx), vt[v].e_vidx);
      check($sformatf("vec%0d:vcnt", v),   int'(victim_cnt), vt[v].e_vcnt);
    end

    // Saturation: 300 hits on entry 2 stop at 255.
    do_reset(2);
    for (int k = 0; k < 300; k++) cyc("sat", 0, 1, 2, 0, 0, 2);
    idle("sat", 2);
    check("sat:rd_cnt", int'(rd_cnt),     255);
    check("sat:vidx",   int'(victim_idx), 0);
    check("sat:vcnt",   int'(victim_cnt), 0);

    // Aging cadence on {8,6,4,2}.
    build_8642();
    for (int k = 0; k < P; k++) cyc("age_tick", 1, 0, 0, 0, 0, 0);
    check("age:busy_rise", int'(sweep_busy), 1);
    check("age:done0",     int'(sweep_done), 0);
    for (int k = 0; k < 3; k++) begin
      idle("age", 0);
      check($sformatf("age:busy%0d", k + 1), int'(sweep_busy), 1);
      check($sformatf("age:done%0d", k + 1), int'(sweep_done), (k == 2) ? 1 : 0);
    end
    idle("age", 0);
    check("age:busy_fall", int'(sweep_busy), 0);
    idle("age", 0);
    check("age:vidx", int'(victim_idx), 3);
    check("age:vcnt", int'(victim_cnt), 1);
    for (int e = 0; e < N; e++) begin
      int exp_a [N];
      exp_a[0] = 4; exp_a[1] = 3; exp_a[2] = 2; exp_a[3] = 1;
      rd_idx = 2'(e);
      #1;
      check($sformatf("age:cnt%0d", e), int'(rd_cnt), exp_a[e]);
    end

    // Collisions: hit while aged, fill with hit, fill while aged.
    build_8642();
    for (int k = 0; k < P; k++) cyc("col_tick", 1, 0, 0, 0, 0, 1);
    idle("col", 1);
    cyc("col", 0, 1, 1, 0, 0, 1);
    check("col:hit_aged", int'(rd_cnt), 4);
    cyc("col", 0, 1, 1, 1, 1, 1);
    check("col:fill_hit", int'(rd_cnt), 1);
    cyc("col", 0, 0, 0, 1, 3, 3);
    check("col:fill_aged", int'(rd_cnt), 1);

    // Pending: next period completes on the last sweep cycle.
    do_reset(0);
    for (int k = 0; k < P; k++) cyc("pend_tick", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc("pend", 1, 0, 0, 0, 0, 0);
      check($sformatf("pend:busy%0d", k), int'(sweep_busy), 1);
      check($sformatf("pend:done%0d", k), int'(sweep_done), (k == 2) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      idle("pend2", 0);
      check($sformatf("pend2:busy%0d", k), int'(sweep_busy), (k < 3) ? 1 : 0);
      check($sformatf("pend2:done%0d", k), int'(sweep_done), (k == 2) ? 1 : 0);
    end
`ifdef LFU_AGE_STATS_EN
    check("pend:sweep_count", int'(sweep_count), 2);
`endif

    // Reset at ptr = 2, then the next sweep starts at entry 0.
    do_reset(0);
    for (int k = 0; k < 4; k++) cyc("mid", 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cyc("mid", 0, 1, 2, 0, 0, 2);
    for (int k = 0; k < P; k++) cyc("mid_tick", 1, 0, 0, 0, 0, 0);
    idle("mid", 0);
    idle("mid", 2);
    do_reset(2);
    check("mid:busy_after", int'(sweep_busy), 0);
    cyc("mid", 0, 1, 0, 0, 0, 0);
    cyc("mid", 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < P; k++) cyc("mid_tick2", 1, 0, 0, 0, 0, 0);
    idle("mid", 0);
    check("mid:first_aged", int'(rd_cnt), 1);
    for (int k = 0; k < 3; k++) idle("mid", 1);

    // Randomized traffic against the model.
    do_reset(0);
    for (int k = 0; k < 3000; k++) begin
      bit tk, hv, fv;
      tk = ($urandom_range(0, 2) != 0);
      hv = ($urandom_range(0, 3) != 0);
      fv = ($urandom_range(0, 7) == 0);
      cyc("rnd", tk, hv, int'($urandom_range(0, N - 1)), fv,
          int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
